ga_fitness_scheduler: RTL

- Sequences the per-member distance (fitness) evaluation of a GA population. Each member is handed to a shared distance unit in turn, one at a time.
- Each returned distance is written into the fitness table. A running best (lowest distance) member is tracked.
- Sits between the generation controller (start/done) and the shared distance datapath.
- A per-member timeout prevents a hung distance unit from stalling the generation loop.

---
 rtl/ga_fitness_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ga_fitness_scheduler.sv
// Sequences fitness evaluation of a GA population through one shared distance unit,
// writing each result to the fitness table and tracking the lowest-distance member.
module ga_fitness_scheduler #(
  parameter int POP_SIZE = 10,
  parameter int IDX_W    = 4,
  parameter int DIST_W   = 16,
  parameter int TIMEOUT  = 64,
  parameter int TMR_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dist_start,
  output logic [IDX_W-1:0]  mem_idx,
  input  logic              dist_done,
  input  logic [DIST_W-1:0] dist_value,
  output logic              fit_we,
  output logic [IDX_W-1:0]  fit_addr,
  output logic [DIST_W-1:0] fit_data,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIST_W-1:0] best_dist,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(POP_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                start_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DIST_W-1:0]   val_q, val_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic                terr_q, terr_d;
  logic                trigger;

  assign trigger = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      idx_q       <= '0;
      timer_q     <= '0;
      val_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '1;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      val_q       <= val_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      terr_q      <= terr_d;
    end
  end

  // A result arriving on the timeout cycle beats the timeout; a timed-out member scores all ones.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    val_d       = val_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          idx_d       = '0;
          best_idx_d  = '0;
          best_dist_d = '1;
          terr_d      = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (dist_done) begin
          val_d   = dist_value;
          state_d = S_WRITE;
        end else if (timer_q == TMR_LIMIT) begin
          val_d   = '1;
          terr_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (val_q < best_dist_q) begin
          best_dist_d = val_q;
          best_idx_d  = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign dist_start  = (state_q == S_ISSUE);
  assign fit_we      = (state_q == S_WRITE);
  assign mem_idx     = idx_q;
  assign fit_addr    = idx_q;
  assign fit_data    = val_q;
  assign best_idx    = best_idx_q;
  assign best_dist   = best_dist_q;
  assign timeout_err = terr_q;

endmodule
